// File: rtl/cp0_if.sv
// Pipeline-side bundle for the coprocessor-0 block: mfc0/mtc0 access, M-stage
// exception context, interrupt lines and the trap/EPC outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;
  logic [31:0] handler_pc;

  modport master (
    output A1, A2, DIn, we, PC, BD, ExcCode, HWInt, EXLClr,
    input  IntReq, EPC, DOut, handler_pc
  );

  modport slave (
    input  A1, A2, DIn, we, PC, BD, ExcCode, HWInt, EXLClr,
    output IntReq, EPC, DOut, handler_pc
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId storage, interrupt and
// exception arbitration, victim PC capture and mfc0 read port.
module cp0_unit #(
  parameter logic [31:0] PRID       = 32'h2019_1221,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic   clk,
  input  logic   reset,
  cp0_if.slave   bus
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_hit;
  logic        exc_hit;
  logic        int_req;
  logic [31:0] pc_victim;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Raw HWInt is used so an interrupt is taken in the cycle its line rises.
  assign int_hit = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_hit = (bus.ExcCode != 5'd0) & ~exl_q;
  assign int_req = int_hit | exc_hit;

  assign pc_victim = bus.BD ? (bus.PC - 32'd4) : bus.PC;

  assign sr_word    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_word = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (int_req) begin
      // A trap discards any mtc0 issued in the same cycle.
      exl_d      = 1'b1;
      bd_d       = bus.BD;
      exc_code_d = int_hit ? 5'd0 : bus.ExcCode;
      epc_d      = pc_victim & 32'hFFFF_FFFC;
    end else begin
      if (bus.we) begin
        if (bus.A2 == AddrSr) begin
          im_d  = bus.DIn[15:10];
          exl_d = bus.DIn[1];
          ie_d  = bus.DIn[0];
        end else if (bus.A2 == AddrEpc) begin
          epc_d = bus.DIn & 32'hFFFF_FFFC;
        end
      end
      // eret beats a simultaneous mtc0 SR, but only for EXL.
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= bus.HWInt;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    bus.DOut = 32'd0;
    unique case (bus.A1)
      AddrSr:    bus.DOut = sr_word;
      AddrCause: bus.DOut = cause_word;
      AddrEpc:   bus.DOut = epc_q;
      AddrPrid:  bus.DOut = PRID;
      default:   bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq     = int_req;
  assign bus.EPC        = epc_q;
  assign bus.handler_pc = HANDLER_PC;

endmodule
